// File: rtl/pc_core_pkg.sv
// Shared types for the program counter core: the command encoding and the
// priority encoder that turns the raw request strobes into a single command.
package pc_core_pkg;

    localparam int PC_WIDTH = 16;

    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_INC,
        CMD_BRANCH,
        CMD_CALL,
        CMD_RET,
        CMD_LOAD
    } pc_cmd_e;

    // load > ret > call > branch > inc > hold
    function automatic pc_cmd_e prio_cmd(input logic load, input logic ret,
                                         input logic call, input logic branch,
                                         input logic inc);
        pc_cmd_e c;
        if (load)        c = CMD_LOAD;
        else if (ret)    c = CMD_RET;
        else if (call)   c = CMD_CALL;
        else if (branch) c = CMD_BRANCH;
        else if (inc)    c = CMD_INC;
        else             c = CMD_HOLD;
        return c;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// LIFO return-address stack: an entry array plus an occupancy count whose
// top entry lives at index count-1. Push when full and pop when empty are ignored.
module pc_return_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [CW-1:0]               count;
    logic [AW-1:0]               top_idx;
    logic [AW-1:0]               wr_idx;
    logic                        do_push;
    logic                        do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && !full && !do_pop;
    assign top_idx = AW'(count - 1'b1);
    assign wr_idx  = AW'(count);
    assign dout    = mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (do_pop) begin
            count <= count - 1'b1;
        end else if (do_push) begin
            count <= count + 1'b1;
        end
    end

    // Entry contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/program_counter_core.sv
// Program counter with hold/inc/load/branch/call/ret and a sticky error flag
// for return-stack overflow and underflow.
module program_counter_core
    import pc_core_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               STACK_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] preset,
    input  logic             stall,
    input  logic             load,
    input  logic             ret,
    input  logic             call,
    input  logic             branch,
    input  logic [WIDTH-1:0] offset,
    input  logic             inc,
    input  logic             clr_err,
    output logic [WIDTH-1:0] pc,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    pc_cmd_e          cmd;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] ret_addr;
    logic             push;
    logic             pop;
    logic             ovf;
    logic             unf;

    assign cmd    = prio_cmd(load, ret, call, branch, inc);
    assign pc_inc = pc + ONE;
    assign ovf    = (cmd == CMD_CALL) && stack_full;
    assign unf    = (cmd == CMD_RET) && stack_empty;
    assign push   = !stall && (cmd == CMD_CALL) && !stack_full;
    assign pop    = !stall && (cmd == CMD_RET) && !stack_empty;

    pc_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (ret_addr),
        .empty (stack_empty),
        .full  (stack_full)
    );

    // Over/underflow falls through to a plain increment.
    always_comb begin
        pc_next = pc;
        unique case (cmd)
            CMD_LOAD:   pc_next = preset;
            CMD_RET:    pc_next = stack_empty ? pc_inc : ret_addr;
            CMD_CALL:   pc_next = stack_full ? pc_inc : preset;
            CMD_BRANCH: pc_next = pc + offset;
            CMD_INC:    pc_next = pc_inc;
            default:    pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VECTOR;
        end else if (!stall) begin
            pc <= pc_next;
        end
    end

    // A new fault in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (!stall) begin
            if (ovf || unf)   err <= 1'b1;
            else if (clr_err) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_program_counter_core.sv
// Directed bench for program_counter_core: hand-computed pc/stack/err values
// checked with immediate assertions after each clock edge.
module tb_program_counter_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] preset = '0;
    logic        stall = 1'b0;
    logic        load = 1'b0;
    logic        ret = 1'b0;
    logic        call = 1'b0;
    logic        branch = 1'b0;
    logic [15:0] offset = '0;
    logic        inc = 1'b0;
    logic        clr_err = 1'b0;
    logic [15:0] pc;
    logic        stack_empty;
    logic        stack_full;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    program_counter_core #(
        .WIDTH        (16),
        .RESET_VECTOR (16'h0000),
        .STACK_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .preset      (preset),
        .stall       (stall),
        .load        (load),
        .ret         (ret),
        .call        (call),
        .branch      (branch),
        .offset      (offset),
        .inc         (inc),
        .clr_err     (clr_err),
        .pc          (pc),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic l, input logic r, input logic c, input logic b,
                       input logic i, input logic [15:0] p, input logic [15:0] o);
        load = l; ret = r; call = c; branch = b; inc = i; preset = p; offset = o;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // async reset mid-cycle
        tick;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_empty", 16'(stack_empty), 16'h1);
        chk("rst_full", 16'(stack_full), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        #2 rst_n = 1'b1;

        drv(0, 0, 0, 0, 1, 16'h0, 16'h0);
        tick; chk("inc1", pc, 16'h0001);
        tick; chk("inc2", pc, 16'h0002);
        tick; chk("inc3", pc, 16'h0003);

        // load and wrap
        drv(1, 0, 0, 0, 0, 16'hFFFE, 16'h0);
        tick; chk("load_fffe", pc, 16'hFFFE);
        drv(0, 0, 0, 0, 1, 16'h0, 16'h0);
        tick; chk("inc_ffff", pc, 16'hFFFF);
        tick; chk("inc_wrap", pc, 16'h0000);

        // branch
        drv(1, 0, 0, 0, 0, 16'h0010, 16'h0);
        tick; chk("load_0010", pc, 16'h0010);
        drv(0, 0, 0, 1, 0, 16'h0, 16'hFFF8);
        tick; chk("br_neg8", pc, 16'h0008);
        drv(0, 0, 0, 1, 0, 16'h0, 16'h0004);
        tick; chk("br_pos4", pc, 16'h000C);

        // nested call/return
        drv(1, 0, 0, 0, 0, 16'h0020, 16'h0);
        tick; chk("load_0020", pc, 16'h0020);
        drv(0, 0, 1, 0, 0, 16'h0100, 16'h0);
        tick; chk("call1", pc, 16'h0100);
        chk("call1_empty", 16'(stack_empty), 16'h0);
        drv(0, 0, 1, 0, 0, 16'h0200, 16'h0);
        tick; chk("call2", pc, 16'h0200);
        drv(0, 1, 0, 0, 0, 16'h0, 16'h0);
        tick; chk("ret1", pc, 16'h0101);
        tick; chk("ret2", pc, 16'h0021);
        chk("ret2_empty", 16'(stack_empty), 16'h1);
        chk("ret2_err", 16'(err), 16'h0);

        // fill the stack, then overflow
        drv(0, 0, 1, 0, 0, 16'h1000, 16'h0); tick;
        drv(0, 0, 1, 0, 0, 16'h2000, 16'h0); tick;
        drv(0, 0, 1, 0, 0, 16'h3000, 16'h0); tick;
        chk("fill3_full", 16'(stack_full), 16'h0);
        drv(0, 0, 1, 0, 0, 16'h4000, 16'h0); tick;
        chk("fill4_pc", pc, 16'h4000);
        chk("fill4_full", 16'(stack_full), 16'h1);
        chk("fill4_err", 16'(err), 16'h0);
        drv(0, 0, 1, 0, 0, 16'h5000, 16'h0);
        tick; chk("ovf_pc", pc, 16'h4001);
        chk("ovf_err", 16'(err), 16'h1);
        chk("ovf_full", 16'(stack_full), 16'h1);

        // load wins over ret/call/inc and leaves the stack alone
        drv(1, 1, 1, 0, 1, 16'h7000, 16'h0);
        tick; chk("prio_pc", pc, 16'h7000);
        chk("prio_full", 16'(stack_full), 16'h1);

        drv(0, 0, 0, 0, 0, 16'h0, 16'h0);
        clr_err = 1'b1;
        tick; chk("clr_err", 16'(err), 16'h0);
        chk("clr_hold_pc", pc, 16'h7000);
        clr_err = 1'b0;

        // drain and underflow
        drv(0, 1, 0, 0, 0, 16'h0, 16'h0);
        tick; chk("pop1", pc, 16'h3001);
        chk("pop1_full", 16'(stack_full), 16'h0);
        tick; chk("pop2", pc, 16'h2001);
        tick; chk("pop3", pc, 16'h1001);
        tick; chk("pop4", pc, 16'h0022);
        chk("pop4_empty", 16'(stack_empty), 16'h1);
        chk("pop4_err", 16'(err), 16'h0);
        tick; chk("unf_pc", pc, 16'h0023);
        chk("unf_err", 16'(err), 16'h1);

        // stall freezes everything, including clr_err
        stall = 1'b1;
        drv(1, 0, 0, 0, 0, 16'hABCD, 16'h0);
        tick; chk("stall_load", pc, 16'h0023);
        drv(0, 0, 1, 0, 0, 16'hABCD, 16'h0);
        clr_err = 1'b1;
        tick; chk("stall_clr_err", 16'(err), 16'h1);
        chk("stall_call_pc", pc, 16'h0023);
        chk("stall_call_empty", 16'(stack_empty), 16'h1);
        stall = 1'b0;

        // underflow with clr_err in the same cycle: set wins
        drv(0, 1, 0, 0, 0, 16'h0, 16'h0);
        tick; chk("setwin_pc", pc, 16'h0024);
        chk("setwin_err", 16'(err), 16'h1);
        clr_err = 1'b0;

        // call at FFFF pushes 0000
        drv(1, 0, 0, 0, 0, 16'hFFFF, 16'h0);
        tick; chk("load_ffff", pc, 16'hFFFF);
        drv(0, 0, 1, 0, 0, 16'h0300, 16'h0);
        tick; chk("call_ffff", pc, 16'h0300);
        drv(0, 1, 0, 0, 0, 16'h0, 16'h0);
        tick; chk("ret_wrap", pc, 16'h0000);

        // reset mid-operation drops the pending ret
        drv(0, 0, 1, 0, 0, 16'h0400, 16'h0);
        tick; chk("call_0400", pc, 16'h0400);
        drv(0, 1, 0, 0, 0, 16'h0, 16'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_pc", pc, 16'h0000);
        chk("rst2_empty", 16'(stack_empty), 16'h1);
        chk("rst2_err", 16'(err), 16'h0);
        tick; chk("rst2_hold", pc, 16'h0000);
        drv(0, 0, 0, 0, 0, 16'h0, 16'h0);
        rst_n = 1'b1;
        tick; chk("rst2_idle", pc, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/program_counter_core.md
Name: program_counter_core

Overview:
- Sequential program-counter register that consumes the 16-bit preset value produced by the preset select stage directly upstream.
- Each cycle it holds, increments, loads the preset, branches relative, or calls/returns through a small return-address stack.
- Output pc drives instruction fetch.

Parameters:
- WIDTH, 16, PC and data width in bits.
- RESET_VECTOR, 16'h0000, PC value on reset.
- STACK_DEPTH, 4, return-stack entries (power of 2, at least 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- preset  input  WIDTH  load/call target from the preset select stage.
- stall  input  1  freeze all state this cycle.
- load  input  1  pc <= preset.
- ret  input  1  pop the return stack into pc.
- call  input  1  push pc+1, then pc <= preset.
- branch  input  1  pc <= pc + offset.
- offset  input  WIDTH  two's-complement branch displacement.
- inc  input  1  pc <= pc + 1.
- clr_err  input  1  clear the sticky error flag.
- pc  output  WIDTH  current program counter.
- stack_empty  output  1  return stack holds 0 entries.
- stack_full  output  1  return stack holds STACK_DEPTH entries.
- err  output  1  sticky stack over/underflow flag.

Behaviour:
- Reset (asynchronous, rst_n low):
  - pc = RESET_VECTOR, stack count = 0, stack_empty = 1, stack_full = 0, err = 0.
  - Stack entry contents are don't-care.
  - Reset mid-operation discards any pending call/ret.
- Register updates happen on the rising clk edge. pc, stack_empty, stack_full and err are registered or derived directly from registered count.
- One-cycle latency: a command sampled at edge N is visible on pc after edge N.
- stall = 1 has highest priority:
  - pc, stack and err all hold, including when clr_err is high.
  - All other commands are ignored and never queued.
- When not stalled, priority is load > ret > call > branch > inc > hold. Only the highest-priority asserted command executes.
- load: pc <= preset. Stack is untouched.
- ret:
  - Count > 0: pc <= top entry, count decrements.
  - Count = 0 (underflow): pc <= pc+1, count stays 0, err <= 1.
- call:
  - Count < STACK_DEPTH: push pc+1, pc <= preset, count increments.
  - Count = STACK_DEPTH (overflow): no push, pc <= pc+1, err <= 1.
- branch: pc <= pc + offset, modulo 2^WIDTH. Offset is already WIDTH bits signed; no extension is needed.
- inc: pc <= pc + 1, modulo 2^WIDTH. 16'hFFFF wraps to 16'h0000 with no flag.
- Pushed return addresses also wrap: a call at 16'hFFFF pushes 16'h0000.
- Stack is LIFO, implemented as an array plus a count pointer. The top entry is at index count-1.
- err is sticky until reset or clr_err. If clr_err and a new over/underflow occur in the same unstalled cycle, err = 1 (set wins).
- stack_empty and stack_full reflect count after the edge.

Decomposition:
- Package pc_core_pkg:
  - WIDTH default.
  - Command enum pc_cmd_e {CMD_HOLD, CMD_INC, CMD_BRANCH, CMD_CALL, CMD_RET, CMD_LOAD}.
  - A priority-encode function that maps the request bits to pc_cmd_e.
- Sub-module pc_return_stack (ports: clk, rst_n, push, pop, din, dout, empty, full):
  - Owns the array and count.
  - Ignores a push when full and a pop when empty.
- The top level holds only the pc register, the next-pc mux and err.

Test Plan:
- Reset and increment: assert rst_n=0 mid-cycle, then release and assert inc for 3 cycles -> pc = 0 immediately on reset, then 1, 2, 3.
- Load and wrap: load preset=16'hFFFE, then inc twice -> pc = FFFE, FFFF, 0000.
- Branch: from pc=16'h0010, branch offset=16'hFFF8 (-8) -> pc = 16'h0008. Next, offset=16'h0004 -> pc = 16'h000C.
- Nested call/return: at pc=16'h0020, call preset=16'h0100, then call preset=16'h0200, then ret, ret -> pc = 0100, 0200, 0101, 0021. stack_empty returns to 1 and err = 0.
- Overflow and underflow:
  - 4 calls fill the stack (stack_full = 1). A 5th call -> pc+1, no push, err = 1.
  - After clr_err, 5 rets -> the 5th gives pc+1 and err = 1.
- Priority and stall:
  - load+ret+call+inc together -> pc = preset, stack count unchanged.
  - stall with load asserted -> pc holds.
  - clr_err while stalled -> err stays 1.
